// File: rtl/regfile_scoreboard.sv
// Register file with decoded write mask, two registered bypassing read ports
// and a per-register busy scoreboard for issue/writeback hazard tracking.
module regfile_scoreboard #(
  parameter int unsigned NREGS    = 8,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned IDXW     = 3,
  parameter bit          ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rsv_en,
  input  logic [IDXW-1:0]  rsv_idx,
  input  logic [IDXW-1:0]  rd0_idx,
  input  logic [IDXW-1:0]  rd1_idx,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd0_busy,
  output logic             rd1_busy,
  output logic [NREGS-1:0] wr_mask,
  output logic [NREGS-1:0] busy_mask,
  output logic             wr_unexp
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [WIDTH-1:0] r_rd0_data;
  logic [WIDTH-1:0] r_rd1_data;
  logic             r_rd0_busy;
  logic             r_rd1_busy;
  logic             r_wr_unexp;

  logic [WIDTH-1:0] w_regs_next [NREGS];
  logic [NREGS-1:0] w_busy_next;
  logic [NREGS-1:0] w_wr_mask;
  logic             w_wr_valid;
  logic             w_rsv_valid;
  logic             w_rd0_valid;
  logic             w_rd1_valid;
  logic [WIDTH-1:0] w_rd0_data;
  logic [WIDTH-1:0] w_rd1_data;
  logic             w_rd0_busy;
  logic             w_rd1_busy;
  logic             w_wr_unexp;

  // In range and not the hardwired zero register.
  function automatic logic idx_valid(input logic [IDXW-1:0] idx);
    return (32'(idx) < NREGS) && !(ZERO_REG && (idx == '0));
  endfunction

  always_comb begin
    w_wr_mask = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      w_wr_mask[i] = wr_en && (int'(wr_idx) == i);
    end
  end

  assign w_wr_valid  = wr_en && idx_valid(wr_idx);
  assign w_rsv_valid = rsv_en && idx_valid(rsv_idx);
  assign w_rd0_valid = idx_valid(rd0_idx);
  assign w_rd1_valid = idx_valid(rd1_idx);

  // Post-edge state; reservation applied after the write so a newer producer wins.
  always_comb begin
    w_regs_next = r_regs;
    w_busy_next = r_busy;
    w_wr_unexp  = 1'b0;
    if (w_wr_valid) begin
      w_regs_next[wr_idx] = wr_data;
      w_busy_next[wr_idx] = 1'b0;
      w_wr_unexp          = !r_busy[wr_idx];
    end
    if (w_rsv_valid) begin
      w_busy_next[rsv_idx] = 1'b1;
    end
  end

  // Read from post-edge state so same-cycle writes and reservations are visible.
  always_comb begin
    w_rd0_data = '0;
    w_rd1_data = '0;
    w_rd0_busy = 1'b0;
    w_rd1_busy = 1'b0;
    if (w_rd0_valid) begin
      w_rd0_data = w_regs_next[rd0_idx];
      w_rd0_busy = w_busy_next[rd0_idx];
    end
    if (w_rd1_valid) begin
      w_rd1_data = w_regs_next[rd1_idx];
      w_rd1_busy = w_busy_next[rd1_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_regs[i] <= '0;
      end
      r_busy     <= '0;
      r_rd0_data <= '0;
      r_rd1_data <= '0;
      r_rd0_busy <= 1'b0;
      r_rd1_busy <= 1'b0;
      r_wr_unexp <= 1'b0;
    end else begin
      r_regs     <= w_regs_next;
      r_busy     <= w_busy_next;
      r_rd0_data <= w_rd0_data;
      r_rd1_data <= w_rd1_data;
      r_rd0_busy <= w_rd0_busy;
      r_rd1_busy <= w_rd1_busy;
      r_wr_unexp <= w_wr_unexp;
    end
  end

  assign rd0_data  = r_rd0_data;
  assign rd1_data  = r_rd1_data;
  assign rd0_busy  = r_rd0_busy;
  assign rd1_busy  = r_rd1_busy;
  assign wr_mask   = w_wr_mask;
  assign busy_mask = r_busy;
  assign wr_unexp  = r_wr_unexp;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (8 regs with zero register,
// 6 regs without) share stimulus and are checked against an array model.
module tb_regfile_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [7:0] wr_data = '0;
  logic       rsv_en = 1'b0;
  logic [2:0] rsv_idx = '0;
  logic [2:0] rd0_idx = '0;
  logic [2:0] rd1_idx = '0;

  logic [7:0] a_rd0_data, a_rd1_data, b_rd0_data, b_rd1_data;
  logic       a_rd0_busy, a_rd1_busy, b_rd0_busy, b_rd1_busy;
  logic [7:0] a_wr_mask, a_busy_mask;
  logic [5:0] b_wr_mask, b_busy_mask;
  logic       a_wr_unexp, b_wr_unexp;

  always #5 clk = ~clk;

  regfile_scoreboard #(.NREGS(8), .WIDTH(8), .IDXW(3), .ZERO_REG(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .rd0_idx(rd0_idx), .rd1_idx(rd1_idx),
    .rd0_data(a_rd0_data), .rd1_data(a_rd1_data), .rd0_busy(a_rd0_busy),
    .rd1_busy(a_rd1_busy), .wr_mask(a_wr_mask), .busy_mask(a_busy_mask),
    .wr_unexp(a_wr_unexp));

  regfile_scoreboard #(.NREGS(6), .WIDTH(8), .IDXW(3), .ZERO_REG(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .rd0_idx(rd0_idx), .rd1_idx(rd1_idx),
    .rd0_data(b_rd0_data), .rd1_data(b_rd1_data), .rd0_busy(b_rd0_busy),
    .rd1_busy(b_rd1_busy), .wr_mask(b_wr_mask), .busy_mask(b_busy_mask),
    .wr_unexp(b_wr_unexp));

  int errors = 0;
  int checks = 0;

  // Model state per instance: k=0 is u_a, k=1 is u_b.
  logic [7:0] m_regs [2][8];
  logic       m_busy [2][8];
  logic [7:0] e_rd0_data [2];
  logic [7:0] e_rd1_data [2];
  logic       e_rd0_busy [2];
  logic       e_rd1_busy [2];
  logic       e_unexp    [2];

  function automatic int nregs(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  function automatic bit is_valid(input int k, input int idx);
    return (idx < nregs(k)) && !((k == 0) && (idx == 0));
  endfunction

  function automatic logic [7:0] exp_busy_mask(input int k);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < nregs(k); i++) m[i] = m_busy[k][i];
    return m;
  endfunction

  function automatic logic [7:0] exp_wr_mask(input int k);
    logic [7:0] one;
    one = 8'd1;
    if (wr_en && (int'(wr_idx) < nregs(k))) return one << wr_idx;
    return 8'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[k][i] = '0;
        m_busy[k][i] = 1'b0;
      end
      e_rd0_data[k] = '0; e_rd1_data[k] = '0;
      e_rd0_busy[k] = 1'b0; e_rd1_busy[k] = 1'b0;
      e_unexp[k] = 1'b0;
    end
  endtask

  // Apply one clock edge worth of the register-file rules to the model.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      e_unexp[k] = wr_en && is_valid(k, int'(wr_idx)) && !m_busy[k][wr_idx];
      if (wr_en && is_valid(k, int'(wr_idx))) begin
        m_regs[k][wr_idx] = wr_data;
        m_busy[k][wr_idx] = 1'b0;
      end
      if (rsv_en && is_valid(k, int'(rsv_idx))) m_busy[k][rsv_idx] = 1'b1;
      e_rd0_data[k] = is_valid(k, int'(rd0_idx)) ? m_regs[k][rd0_idx] : 8'd0;
      e_rd0_busy[k] = is_valid(k, int'(rd0_idx)) ? m_busy[k][rd0_idx] : 1'b0;
      e_rd1_data[k] = is_valid(k, int'(rd1_idx)) ? m_regs[k][rd1_idx] : 8'd0;
      e_rd1_busy[k] = is_valid(k, int'(rd1_idx)) ? m_busy[k][rd1_idx] : 1'b0;
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_a_rd0d"}, 32'(a_rd0_data), 32'(e_rd0_data[0]));
    chk({tag, "_a_rd1d"}, 32'(a_rd1_data), 32'(e_rd1_data[0]));
    chk({tag, "_a_rd0b"}, 32'(a_rd0_busy), 32'(e_rd0_busy[0]));
    chk({tag, "_a_rd1b"}, 32'(a_rd1_busy), 32'(e_rd1_busy[0]));
    chk({tag, "_a_bmask"}, 32'(a_busy_mask), 32'(exp_busy_mask(0)));
    chk({tag, "_a_unexp"}, 32'(a_wr_unexp), 32'(e_unexp[0]));
    chk({tag, "_b_rd0d"}, 32'(b_rd0_data), 32'(e_rd0_data[1]));
    chk({tag, "_b_rd1d"}, 32'(b_rd1_data), 32'(e_rd1_data[1]));
    chk({tag, "_b_rd0b"}, 32'(b_rd0_busy), 32'(e_rd0_busy[1]));
    chk({tag, "_b_rd1b"}, 32'(b_rd1_busy), 32'(e_rd1_busy[1]));
    chk({tag, "_b_bmask"}, 32'(b_busy_mask), 32'(exp_busy_mask(1)));
    chk({tag, "_b_unexp"}, 32'(b_wr_unexp), 32'(e_unexp[1]));
  endtask

  // Inputs are set by the caller just after an edge; check comb mask, clock, check regs.
  task automatic step(input string tag);
    #2;
    chk({tag, "_a_wmask"}, 32'(a_wr_mask), 32'(exp_wr_mask(0)));
    chk({tag, "_b_wmask"}, 32'(b_wr_mask), 32'(exp_wr_mask(1)));
    model_edge();
    @(posedge clk);
    #1;
    check_outs(tag);
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_outs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Read every index on both ports after reset.
    for (int i = 0; i < 8; i++) begin
      rd0_idx = 3'(i); rd1_idx = 3'(7 - i);
      step("rd_reset");
    end

    rsv_en = 1'b1; rsv_idx = 3'd3;
    step("rsv3");
    chk("rsv3_mask_const", 32'(a_busy_mask), 32'h08);

    idle(); wr_en = 1'b1; wr_idx = 3'd3; wr_data = 8'hA5; rd0_idx = 3'd3;
    step("wr3");
    chk("wr3_rd0d_const", 32'(a_rd0_data), 32'hA5);
    chk("wr3_rd0b_const", 32'(a_rd0_busy), 32'h0);
    chk("wr3_mask_const", 32'(a_busy_mask), 32'h0);
    chk("wr3_unexp_const", 32'(a_wr_unexp), 32'h0);

    wr_en = 1'b1; wr_idx = 3'd5; wr_data = 8'h3C; rsv_en = 1'b1; rsv_idx = 3'd5; rd1_idx = 3'd5;
    step("wr_rsv5");
    chk("wr_rsv5_rd1d_const", 32'(a_rd1_data), 32'h3C);
    chk("wr_rsv5_rd1b_const", 32'(a_rd1_busy), 32'h1);
    chk("wr_rsv5_bit5_const", 32'(a_busy_mask[5]), 32'h1);

    idle(); wr_en = 1'b1; wr_idx = 3'd2; wr_data = 8'h5A;
    step("wr2_unexp");
    chk("wr2_unexp_const", 32'(a_wr_unexp), 32'h1);
    idle(); rd0_idx = 3'd2;
    step("wr2_unexp_drop");
    chk("wr2_unexp_drop_const", 32'(a_wr_unexp), 32'h0);
    chk("wr2_read_const", 32'(a_rd0_data), 32'h5A);

    // Zero register on u_a; u_b treats index 0 as ordinary.
    wr_en = 1'b1; wr_idx = 3'd0; wr_data = 8'hFF; rsv_en = 1'b1; rsv_idx = 3'd0;
    rd0_idx = 3'd0; rd1_idx = 3'd0;
    step("zero_reg");
    chk("zero_a_rd0d_const", 32'(a_rd0_data), 32'h0);
    chk("zero_a_bit0_const", 32'(a_busy_mask[0]), 32'h0);
    chk("zero_b_rd0d_const", 32'(b_rd0_data), 32'hFF);

    idle(); wr_en = 1'b1; wr_idx = 3'd6; wr_data = 8'h77; rd0_idx = 3'd6; rd1_idx = 3'd7;
    #2;
    chk("wmask6_a_const", 32'(a_wr_mask), 32'h40);
    chk("wmask6_b_const", 32'(b_wr_mask), 32'h00);
    step("wr6");

    idle(); rsv_en = 1'b1; rsv_idx = 3'd1;
    step("rsv1");
    rsv_idx = 3'd4;
    step("rsv4");
    chk("rsv14_mask_const", 32'(a_busy_mask & 8'h12), 32'h12);
    idle();
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("async_rst");
    chk("async_rst_mask_const", 32'(a_busy_mask), 32'h0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int n = 0; n < 300; n++) begin
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_idx  = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      rsv_en  = ($urandom_range(0, 99) < 50);
      rsv_idx = ($urandom_range(0, 3) == 0) ? wr_idx : 3'($urandom_range(0, 7));
      rd0_idx = 3'($urandom_range(0, 7));
      rd1_idx = ($urandom_range(0, 3) == 0) ? rd0_idx : 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
